// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants and FSM state type for the four-requester FIFO write arbiter.
// Pure declarations: no latency, no flow control.
package fifo_write_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int OWNER_W = 2;
  localparam int WCNT_W  = 16;
  // Wide enough to hold BURST_LEN (max 8) after the final beat increments.
  localparam int BEAT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick4.sv
// Round-robin pick of one of four requests, searching upward from last_owner+1 with wrap.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick4
  import fifo_write_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] last_owner_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [OWNER_W-1:0] winner_idx_o,
  output logic               found_o
);

  logic [OWNER_W-1:0] cand;
  logic               hit;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    cand         = '0;
    hit          = 1'b0;
    // k = NUM_REQ wraps back onto last_owner itself, so it is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_owner_i + OWNER_W'(k);
      if (!hit && req_i[cand]) begin
        hit            = 1'b1;
        winner_o[cand] = 1'b1;
        winner_idx_o   = cand;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst round-robin arbiter for four writers into one FIFO; grant is registered, write_en/ack same-cycle.
// mem_full stalls the burst in place (no timeout); owner dropping req ends the burst.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 8
) (
  input  logic                      write_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      mem_full,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      write_en,
  output logic [DATA_W-1:0]         data_in,
  output logic                      busy,
  output logic [WCNT_W-1:0]         write_count
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [WCNT_W-1:0]  write_count_q, write_count_d;
  logic [OWNER_W-1:0] last_owner_q, last_owner_d;

  logic [NUM_REQ-1:0] rr_winner;
  logic [OWNER_W-1:0] rr_winner_idx;
  logic               rr_found;
  logic               owner_req;
  logic               last_beat;
  logic               wr_fire;

  rr_pick4 u_rr_pick4 (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .winner_o     (rr_winner),
    .winner_idx_o (rr_winner_idx),
    .found_o      (rr_found)
  );

  assign owner_req = |(grant_q & req);
  assign last_beat = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    write_count_d = write_count_q;
    last_owner_d  = last_owner_q;
    wr_fire       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req && !mem_full && rr_found) begin
          state_d      = BURST;
          grant_d      = rr_winner;
          beat_cnt_d   = '0;
          last_owner_d = rr_winner_idx;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (!mem_full) begin
          wr_fire       = 1'b1;
          beat_cnt_d    = beat_cnt_q + BEAT_W'(1);
          write_count_d = write_count_q + WCNT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      beat_cnt_q    <= '0;
      write_count_q <= '0;
      last_owner_q  <= OWNER_W'(NUM_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      write_count_q <= write_count_d;
      last_owner_q  <= last_owner_d;
    end
  end

  // AND-OR mux on the registered one-hot grant; yields zero whenever idle.
  always_comb begin
    data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        data_in = data_in | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant       = grant_q;
  assign write_en    = wr_fire;
  assign ack         = grant_q & {NUM_REQ{wr_fire}};
  assign busy        = (state_q == BURST);
  assign write_count = write_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scoreboard bench for fifo_write_arbiter with default BURST_LEN=4, DATA_W=8.
module tb_fifo_write_arbiter;

  logic        write_clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        mem_full;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        write_en;
  logic [7:0]  data_in;
  logic        busy;
  logic [15:0] write_count;

  fifo_write_arbiter #(.BURST_LEN(4), .DATA_W(8)) dut (
    .write_clk   (write_clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .mem_full    (mem_full),
    .grant       (grant),
    .ack         (ack),
    .write_en    (write_en),
    .data_in     (data_in),
    .busy        (busy),
    .write_count (write_count)
  );

  always #5 write_clk = ~write_clk;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  total    = 0;
  int  bad      = 0;
  bit  free_run = 1'b0;
  int  n_wr     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input int owner, input int beats);
    wr_t e;
    e.ack = 4'(1 << owner);
    e.dat = req_data[owner*8 +: 8];
    for (int i = 0; i < beats; i++) exp_q.push_back(e);
  endtask

  // One clock: sample the current cycle's write, then advance past the edge.
  task automatic tick();
    wr_t e;
    #1;
    if (write_en === 1'b1) begin
      n_wr++;
      if (!free_run) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(write_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_ack", 32'(ack), 32'(e.ack));
          chk("wr_data", 32'(data_in), 32'(e.dat));
        end
      end
    end
    @(posedge write_clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int c;
    reset    = 1'b1;
    req      = 4'b0001;
    mem_full = 1'b0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    #2 reset = 1'b0;

    // Reset state, with a request already present.
    repeat (2) @(posedge write_clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wcnt", 32'(write_count), 32'h0);
    chk("rst_wen", 32'(write_en), 32'h0);
    chk("rst_data", 32'(data_in), 32'h0);
    reset = 1'b1;
    #1;
    chk("pre_edge_grant", 32'(grant), 32'h0);

    // Single requester: grant, four writes, bubble, regrant.
    expect_wr(0, 4);
    tick();
    chk("s1_grant", 32'(grant), 32'h1);
    chk("s1_busy", 32'(busy), 32'h1);
    repeat (4) tick();
    chk("s1_bubble_grant", 32'(grant), 32'h0);
    chk("s1_bubble_wen", 32'(write_en), 32'h0);
    chk("s1_bubble_data", 32'(data_in), 32'h0);
    chk("s1_wcnt", 32'(write_count), 32'd4);
    tick();
    chk("s1_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    chk("s1_drop_grant", 32'(grant), 32'h0);
    chk("s1_wcnt_hold", 32'(write_count), 32'd4);

    // All four requesting: owner order 0,1,2,3,0.
    pulse_reset();
    req      = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int b = 0; b < 4; b++) begin
      expect_wr(b, 4);
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << b));
      repeat (4) tick();
      chk("rr_idle", 32'(busy), 32'h0);
    end
    chk("rr_wcnt", 32'(write_count), 32'd16);
    tick();
    chk("rr_fifth_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    chk("rr_end_grant", 32'(grant), 32'h0);

    // FIFO full stall after two writes of a burst.
    pulse_reset();
    req      = 4'b0100;
    req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    expect_wr(2, 4);
    tick();
    chk("st_grant", 32'(grant), 32'h4);
    repeat (2) tick();
    mem_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wen", 32'(write_en), 32'h0);
      chk("st_grant_hold", 32'(grant), 32'h4);
      tick();
    end
    mem_full = 1'b0;
    #1;
    chk("st_resume_wen", 32'(write_en), 32'h1);
    repeat (2) tick();
    chk("st_done_grant", 32'(grant), 32'h0);
    chk("st_wcnt", 32'(write_count), 32'd4);
    req = 4'b0000;

    // Owner drops after one write while requester 2 waits.
    pulse_reset();
    req      = 4'b0101;
    req_data = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
    expect_wr(0, 1);
    tick();
    chk("dr_grant", 32'(grant), 32'h1);
    tick();
    req = 4'b0100;
    #1;
    chk("dr_wen", 32'(write_en), 32'h0);
    tick();
    chk("dr_idle_grant", 32'(grant), 32'h0);
    tick();
    chk("dr_regrant", 32'(grant), 32'h4);

    // Reset mid-burst with a non-owner also requesting.
    req = 4'b0101;
    expect_wr(2, 2);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_wen", 32'(write_en), 32'h0);
    chk("mr_ack", 32'(ack), 32'h0);
    chk("mr_wcnt", 32'(write_count), 32'h0);
    reset = 1'b1;
    tick();
    chk("mr_regrant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();

    // write_count wrap after 65536 accepted writes.
    pulse_reset();
    req      = 4'b0001;
    free_run = 1'b1;
    n_wr     = 0;
    c        = 0;
    while (n_wr < 65535 && c < 90000) begin
      tick();
      c++;
    end
    chk("wrap_pre", 32'(write_count), 32'hFFFF);
    while (n_wr < 65536 && c < 90000) begin
      tick();
      c++;
    end
    chk("wrap_zero", 32'(write_count), 32'h0);
    chk("wrap_nwr", 32'(n_wr), 32'd65536);
    free_run = 1'b0;
    req      = 4'b0000;
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
